cycle_sequencer: RTL and testbench

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 141 ++++++++++++++
 tb/tb_cycle_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - multi-cycle instruction sequencer with memory timeout and trap
module cycle_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [2:0]  instr_type,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  state,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pcsrc,
  output logic        busy,
  output logic        instr_done,
  output logic        illegal,
  output logic [15:0] retired
);

  // instr_type carries opcode[6:4]; "type" itself is a reserved word.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0000,
    ST_FETCH   = 4'b0001,
    ST_EXEC    = 4'b0010,
    ST_MEM     = 4'b0100,
    ST_MEMWAIT = 4'b0101,
    ST_BRANCH  = 4'b0110,
    ST_TRAP    = 4'b1000,
    ST_WB      = 4'b1111
  } state_t;

  state_t      state_q, state_d;
  logic        pcsrc_q, pcsrc_d;
  logic        illegal_q, illegal_d;
  logic [15:0] retired_q, retired_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  wait_cnt_inc;
  logic        taken;

  // State register and sequencer-owned flags; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pcsrc_q    <= 1'b0;
      illegal_q  <= 1'b0;
      retired_q  <= 16'h0000;
      wait_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pcsrc_q    <= pcsrc_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic; the wait counter trips when its incremented value reaches 255,
  // which gives exactly 255 MEMWAIT cycles, and mem_ready is tested first so it wins.
  always_comb begin
    state_d      = state_q;
    pcsrc_d      = pcsrc_q;
    illegal_d    = illegal_q;
    retired_d    = retired_q;
    wait_cnt_d   = wait_cnt_q;
    wait_cnt_inc = wait_cnt_q + 8'd1;
    taken        = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          pcsrc_d = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        case (instr_type)
          3'b000, 3'b010: state_d = ST_MEM;
          3'b001, 3'b011: state_d = ST_WB;
          3'b110:         state_d = ST_BRANCH;
          default: begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = ST_WB;
        end else begin
          state_d    = ST_MEMWAIT;
          wait_cnt_d = 8'h00;
        end
      end
      ST_MEMWAIT: begin
        if (mem_ready) begin
          state_d = ST_WB;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == 8'hFF) begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        end
      end
      ST_BRANCH: begin
        if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
          state_d = ST_WB;
          pcsrc_d = taken;
        end else begin
          state_d   = ST_TRAP;
          pcsrc_d   = 1'b0;
          illegal_d = 1'b1;
        end
      end
      ST_WB: begin
        retired_d = retired_q + 16'd1;
        if (run) begin
          state_d = ST_FETCH;
          pcsrc_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs come only from registers, so no input reaches an output combinationally.
  always_comb begin
    state      = state_q;
    irwrite    = (state_q == ST_FETCH);
    pcwrite    = (state_q == ST_WB);
    instr_done = (state_q == ST_WB);
    busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    pcsrc      = pcsrc_q;
    illegal    = illegal_q;
    retired    = retired_q;
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - self-checking bench for cycle_sequencer
module tb_cycle_sequencer;

  localparam logic [3:0] S_IDLE = 4'b0000, S_FETCH = 4'b0001, S_EXEC = 4'b0010, S_MEM = 4'b0100;
  localparam logic [3:0] S_MEMWAIT = 4'b0101, S_BRANCH = 4'b0110, S_TRAP = 4'b1000, S_WB = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [2:0]  instr_type = 3'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  state;
  logic        irwrite, pcwrite, pcsrc, busy, instr_done, illegal;
  logic [15:0] retired;
  logic [9:0]  obs;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] ret_m = 16'h0000;
  logic [3:0]  exp_seq[$];

  typedef struct {
    logic [2:0] t;
    logic [2:0] f3;
    logic       z;
    int         dly;
    logic       ra;
    int         cyc;
    logic       pc;
    logic       trap;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  cycle_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .instr_type(instr_type), .funct3(funct3),
    .zero(zero), .mem_ready(mem_ready), .state(state), .irwrite(irwrite),
    .pcwrite(pcwrite), .pcsrc(pcsrc), .busy(busy), .instr_done(instr_done),
    .illegal(illegal), .retired(retired)
  );

  assign obs = {state, irwrite, pcwrite, instr_done, busy, illegal, pcsrc};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_vec(input logic [3:0] st, input logic pc);
    return {st, st == S_FETCH, st == S_WB, st == S_WB, (st != S_IDLE) && (st != S_TRAP), st == S_TRAP, pc};
  endfunction

  // Reference state walk for one instruction, from the opcode/latency rules.
  task automatic build_seq(input logic [2:0] t, input logic [2:0] f3, input int dly);
    exp_seq = {};
    exp_seq.push_back(S_FETCH);
    exp_seq.push_back(S_EXEC);
    if (t == 3'd1 || t == 3'd3) begin
      exp_seq.push_back(S_WB);
    end else if (t == 3'd6) begin
      exp_seq.push_back(S_BRANCH);
      exp_seq.push_back((f3 <= 3'd1) ? S_WB : S_TRAP);
    end else if (t == 3'd0 || t == 3'd2) begin
      exp_seq.push_back(S_MEM);
      for (int k = 1; k <= dly && k <= 255; k++) exp_seq.push_back(S_MEMWAIT);
      exp_seq.push_back((dly <= 255) ? S_WB : S_TRAP);
    end else begin
      exp_seq.push_back(S_TRAP);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("reset_vec", 32'(obs), 32'(exp_vec(S_IDLE, 1'b0)));
    chk("reset_retired", 32'(retired), 32'h0);
    rst = 1'b0;
    ret_m = 16'h0000;
  endtask

  // Called when the next rising edge enters FETCH (from IDLE or a WB with run=1).
  // mem_ready rises on the dly-th MEMWAIT cycle (dly=0 means ready in MEM).
  task automatic do_instr(input logic [2:0] t, input logic [2:0] f3, input logic z, input int dly,
                          input logic ra, output int ncyc, output logic pc_end, output logic trap_end);
    logic       taken;
    logic [3:0] est;
    build_seq(t, f3, dly);
    taken = (t == 3'd6) && (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z));
    instr_type = t;
    funct3 = f3;
    zero = z;
    run = 1'b1;
    mem_ready = 1'b0;
    ncyc = 0;
    pc_end = 1'b0;
    trap_end = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) run = ra;
      est = (i < exp_seq.size()) ? exp_seq[i] : S_IDLE;
      chk($sformatf("state[%0d]", i), 32'(obs), 32'(exp_vec(est, (est == S_WB) && taken)));
      chk($sformatf("retired[%0d]", i), 32'(retired), 32'(ret_m));
      mem_ready = (i == 2 + dly);
      if (instr_done || illegal) begin
        ncyc = i + 1;
        pc_end = pcsrc;
        trap_end = illegal;
        break;
      end
    end
    mem_ready = 1'b0;
    chk("seq_len", 32'(ncyc), 32'(exp_seq.size()));
    if (ncyc != 0 && !trap_end) ret_m = ret_m + 16'd1;
  endtask

  task automatic after_instr(input logic ra, input logic trap_end);
    if (trap_end) begin
      run = 1'b1;
      mem_ready = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("trap_hold", 32'(obs), 32'(exp_vec(S_TRAP, 1'b0)));
      end
      mem_ready = 1'b0;
      do_reset();
    end else if (!ra) begin
      @(negedge clk);
      chk("stop_state", 32'(state), 32'(S_IDLE));
      chk("stop_busy", 32'(busy), 32'h0);
      chk("stop_done", 32'(instr_done), 32'h0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   ncyc;
    logic pc_end, trap_end;
    logic [2:0] rt, rf;
    logic rz, rra;
    int   rd;

    tbl[0]  = '{3'd3, 3'd0, 1'b0, 0,   1'b1, 3,   1'b0, 1'b0};
    tbl[1]  = '{3'd1, 3'd0, 1'b0, 0,   1'b0, 3,   1'b0, 1'b0};
    tbl[2]  = '{3'd0, 3'd0, 1'b0, 0,   1'b1, 4,   1'b0, 1'b0};
    tbl[3]  = '{3'd0, 3'd0, 1'b0, 3,   1'b1, 7,   1'b0, 1'b0};
    tbl[4]  = '{3'd6, 3'd0, 1'b1, 0,   1'b1, 4,   1'b1, 1'b0};
    tbl[5]  = '{3'd6, 3'd0, 1'b0, 0,   1'b1, 4,   1'b0, 1'b0};
    tbl[6]  = '{3'd6, 3'd1, 1'b1, 0,   1'b1, 4,   1'b0, 1'b0};
    tbl[7]  = '{3'd6, 3'd1, 1'b0, 0,   1'b0, 4,   1'b1, 1'b0};
    tbl[8]  = '{3'd6, 3'd2, 1'b1, 0,   1'b1, 4,   1'b0, 1'b1};
    tbl[9]  = '{3'd4, 3'd0, 1'b0, 0,   1'b1, 3,   1'b0, 1'b1};
    tbl[10] = '{3'd2, 3'd0, 1'b0, 255, 1'b1, 259, 1'b0, 1'b0};
    tbl[11] = '{3'd2, 3'd0, 1'b0, 300, 1'b1, 259, 1'b0, 1'b1};
    tbl[12] = '{3'd7, 3'd0, 1'b0, 0,   1'b1, 3,   1'b0, 1'b1};

    do_reset();
    @(negedge clk);
    chk("idle_hold", 32'(obs), 32'(exp_vec(S_IDLE, 1'b0)));

    // Vector table
    for (int v = 0; v < 13; v++) begin
      do_instr(tbl[v].t, tbl[v].f3, tbl[v].z, tbl[v].dly, tbl[v].ra, ncyc, pc_end, trap_end);
      chk($sformatf("tbl%0d_cycles", v), 32'(ncyc), 32'(tbl[v].cyc));
      chk($sformatf("tbl%0d_pcsrc", v), 32'(pc_end), 32'(tbl[v].pc));
      chk($sformatf("tbl%0d_trap", v), 32'(trap_end), 32'(tbl[v].trap));
      after_instr(tbl[v].ra, trap_end);
    end

    // Counter wrap, then stop on run=0 in WB
    do_reset();
    @(negedge clk);
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    ret_m = 16'hFFFF;
    chk("preload", 32'(retired), 32'hFFFF);
    do_instr(3'd1, 3'd0, 1'b0, 0, 1'b0, ncyc, pc_end, trap_end);
    after_instr(1'b0, trap_end);
    chk("wrap", 32'(retired), 32'h0);

    // Reset asserted in MEMWAIT, then a clean restart
    do_reset();
    do_instr(3'd3, 3'd0, 1'b0, 0, 1'b1, ncyc, pc_end, trap_end);
    instr_type = 3'd0;
    mem_ready = 1'b0;
    run = 1'b1;
    build_seq(3'd0, 3'd0, 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("mw_state[%0d]", i), 32'(state), 32'(exp_seq[i]));
    end
    do_reset();
    do_instr(3'd0, 3'd0, 1'b0, 2, 1'b0, ncyc, pc_end, trap_end);
    after_instr(1'b0, trap_end);
    chk("restart_retired", 32'(retired), 32'h1);

    // Randomized instruction stream against the reference walk
    for (int n = 0; n < 40; n++) begin
      rt  = 3'($urandom_range(0, 7));
      rf  = 3'($urandom_range(0, 2));
      rz  = 1'($urandom_range(0, 1));
      rd  = int'($urandom_range(0, 4));
      rra = 1'($urandom_range(0, 1));
      do_instr(rt, rf, rz, rd, rra, ncyc, pc_end, trap_end);
      after_instr(rra, trap_end);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
